// File: rtl/game_pkg.sv
// Shared encodings and display widths for the LED-chase game sequencer.
// Holds the state codes, score/level widths and the countdown-seconds helper.
package game_pkg;

  localparam int STATE_W    = 3;
  localparam int SCORE_W    = 10;
  localparam int LEVEL_W    = 4;
  localparam int TICK_CNT_W = 16;

  localparam logic [STATE_W-1:0] IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] COUNT = 3'd1;
  localparam logic [STATE_W-1:0] RUN   = 3'd2;
  localparam logic [STATE_W-1:0] PAUSE = 3'd3;
  localparam logic [STATE_W-1:0] LEVEL = 3'd4;
  localparam logic [STATE_W-1:0] OVER  = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = IDLE,
    ST_COUNT = COUNT,
    ST_RUN   = RUN,
    ST_PAUSE = PAUSE,
    ST_LEVEL = LEVEL,
    ST_OVER  = OVER
  } state_e;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 10'd999;

  // ceil(remaining/100) clamped to 1..3, done with compares instead of a divider.
  function automatic logic [1:0] cd_from_remaining(input logic [TICK_CNT_W-1:0] rem);
    if (rem > TICK_CNT_W'(200))      return 2'd3;
    else if (rem > TICK_CNT_W'(100)) return 2'd2;
    else                             return 2'd1;
  endfunction

endpackage

// File: rtl/game_sequencer_tick_prescaler.sv
// Tick prescaler: one-cycle tick every DIV enabled cycles, restartable via clr.
module tick_prescaler #(
  parameter int DIV = 500000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round/level controller for the LED-chase reaction game.
// Optional lives support is enabled with `define GAME_SEQ_LIVES_EN.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV       = 500000,
  parameter int COUNT_TICKS    = 300,
  parameter int LEVEL_TICKS    = 100,
  parameter int BASE_PERIOD    = 5000000,
  parameter int PERIOD_STEP    = 500000,
  parameter int MIN_PERIOD     = 1000000,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 9
`ifdef GAME_SEQ_LIVES_EN
  ,
  parameter int LIVES          = 3
`endif
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start_p,
  input  logic               pause_p,
  input  logic               hit_p,
  input  logic               miss_p,
  output logic               run_en,
  output logic               load,
  output logic [31:0]        period,
  output logic [LEVEL_W-1:0] level,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         cd_sec,
  output logic [STATE_W-1:0] state
);

  localparam int HIT_W = $clog2(HITS_PER_LEVEL + 1);

  localparam logic [TICK_CNT_W-1:0] COUNT_LAST  = TICK_CNT_W'(COUNT_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] LEVEL_LAST  = TICK_CNT_W'(LEVEL_TICKS - 1);
  localparam logic [TICK_CNT_W-1:0] COUNT_TOTAL = TICK_CNT_W'(COUNT_TICKS);
  localparam logic [LEVEL_W-1:0]    LEVEL_TOP   = LEVEL_W'(MAX_LEVEL);
  localparam logic [HIT_W-1:0]      HIT_TARGET  = HIT_W'(HITS_PER_LEVEL);
  localparam logic [31:0]           BASE_P      = 32'(BASE_PERIOD);
  localparam logic [31:0]           MIN_P       = 32'(MIN_PERIOD);
  localparam logic signed [32:0]    BASE_S      = 33'(BASE_PERIOD);
  localparam logic signed [32:0]    STEP_S      = 33'(PERIOD_STEP);
  localparam logic signed [32:0]    MIN_S       = 33'(MIN_PERIOD);

  state_e                  state_q, state_d;
  logic                    run_en_q, run_en_d;
  logic                    load_q, load_d;
  logic [31:0]             period_q, period_d;
  logic [LEVEL_W-1:0]      level_q, level_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [1:0]              cd_q, cd_d;
  logic [TICK_CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HIT_W-1:0]        hit_cnt_q, hit_cnt_d;
  logic signed [32:0]      period_calc;
  logic                    tick, presc_clr, presc_en;
`ifdef GAME_SEQ_LIVES_EN
  logic [1:0]              lives_q, lives_d;
`endif

  assign presc_en = (state_q == ST_COUNT) || (state_q == ST_LEVEL);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_tick_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    level_d    = level_q;
    score_d    = score_q;
    tick_cnt_d = tick_cnt_q;
    hit_cnt_d  = hit_cnt_q;
`ifdef GAME_SEQ_LIVES_EN
    lives_d    = lives_q;
`endif
    // Period for the level being entered: BASE - (new_level-1)*STEP == BASE - level_q*STEP.
    period_calc = BASE_S - $signed({{(33 - LEVEL_W){1'b0}}, level_q}) * STEP_S;

    unique case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          state_d   = ST_COUNT;
          score_d   = '0;
          level_d   = LEVEL_W'(1);
          period_d  = BASE_P;
          hit_cnt_d = '0;
`ifdef GAME_SEQ_LIVES_EN
          lives_d   = 2'(LIVES);
`endif
        end
      end
      ST_COUNT: begin
        if (tick) begin
          if (tick_cnt_q == COUNT_LAST) state_d = ST_RUN;
          else                          tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (miss_p) begin
`ifdef GAME_SEQ_LIVES_EN
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? ST_OVER : ST_COUNT;
`else
          state_d = ST_OVER;
`endif
        end else if (hit_p) begin
          if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
          if ((hit_cnt_q + HIT_W'(1)) == HIT_TARGET) begin
            hit_cnt_d = '0;
            if (level_q < LEVEL_TOP) begin
              state_d  = ST_LEVEL;
              level_d  = level_q + LEVEL_W'(1);
              period_d = (period_calc < MIN_S) ? MIN_P : period_calc[31:0];
            end
          end else begin
            hit_cnt_d = hit_cnt_q + HIT_W'(1);
          end
        end else if (pause_p) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_p) state_d = ST_RUN;
      end
      ST_LEVEL: begin
        if (tick) begin
          if (tick_cnt_q == LEVEL_LAST) state_d = ST_RUN;
          else                          tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
        end
      end
      ST_OVER: begin
        if (start_p) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    presc_clr = (state_d != state_q) && ((state_d == ST_COUNT) || (state_d == ST_LEVEL));
    if (presc_clr) tick_cnt_d = '0;

    run_en_d = (state_d == ST_RUN);
    load_d   = (state_d == ST_RUN) && ((state_q == ST_COUNT) || (state_q == ST_LEVEL));
    cd_d     = (state_d == ST_COUNT) ? cd_from_remaining(COUNT_TOTAL - tick_cnt_d) : 2'd0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      run_en_q   <= 1'b0;
      load_q     <= 1'b0;
      period_q   <= BASE_P;
      level_q    <= LEVEL_W'(1);
      score_q    <= '0;
      cd_q       <= 2'd0;
      tick_cnt_q <= '0;
      hit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_en_q   <= run_en_d;
      load_q     <= load_d;
      period_q   <= period_d;
      level_q    <= level_d;
      score_q    <= score_d;
      cd_q       <= cd_d;
      tick_cnt_q <= tick_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end

`ifdef GAME_SEQ_LIVES_EN
  always_ff @(posedge CLK) begin
    if (RESET) lives_q <= 2'(LIVES);
    else       lives_q <= lives_d;
  end
  assign lives = lives_q;
`else
  assign lives = 2'd0;
`endif

  assign state  = state_q;
  assign run_en = run_en_q;
  assign load   = load_q;
  assign period = period_q;
  assign level  = level_q;
  assign score  = score_q;
  assign cd_sec = cd_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with small tick/period parameters.
// Miss behaviour expectations follow whether GAME_SEQ_LIVES_EN is defined.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_p = 1'b0, pause_p = 1'b0, hit_p = 1'b0, miss_p = 1'b0;
  logic        run_en, load;
  logic [31:0] period;
  logic [3:0]  level;
  logic [1:0]  lives;
  logic [9:0]  score;
  logic [1:0]  cd_sec;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

`ifdef GAME_SEQ_LIVES_EN
  localparam logic [1:0] RST_LIVES = 2'd3;
`else
  localparam logic [1:0] RST_LIVES = 2'd0;
`endif

  game_sequencer #(
    .TICK_DIV       (4),
    .COUNT_TICKS    (3),
    .LEVEL_TICKS    (2),
    .BASE_PERIOD    (100),
    .PERIOD_STEP    (30),
    .MIN_PERIOD     (20),
    .HITS_PER_LEVEL (2),
    .MAX_LEVEL      (9)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .start_p (start_p),
    .pause_p (pause_p),
    .hit_p   (hit_p),
    .miss_p  (miss_p),
    .run_en  (run_en),
    .load    (load),
    .period  (period),
    .level   (level),
    .lives   (lives),
    .score   (score),
    .cd_sec  (cd_sec),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  // One cycle of input pulses, sampled on the next edge; outputs are then settled.
  task automatic drive(input logic s, input logic p, input logic h, input logic m);
    start_p = s; pause_p = p; hit_p = h; miss_p = m;
    step();
    start_p = 1'b0; pause_p = 1'b0; hit_p = 1'b0; miss_p = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (state  !== 3'd0)      begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (run_en !== 1'b0)      begin failures++; $display("FAIL reset_run_en: got %0b want 0", run_en); end
    checks++; if (load   !== 1'b0)      begin failures++; $display("FAIL reset_load: got %0b want 0", load); end
    checks++; if (period !== 32'd100)   begin failures++; $display("FAIL reset_period: got %0d want 100", period); end
    checks++; if (level  !== 4'd1)      begin failures++; $display("FAIL reset_level: got %0d want 1", level); end
    checks++; if (lives  !== RST_LIVES) begin failures++; $display("FAIL reset_lives: got %0d want %0d", lives, RST_LIVES); end
    checks++; if (score  !== 10'd0)     begin failures++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (cd_sec !== 2'd0)      begin failures++; $display("FAIL reset_cd_sec: got %0d want 0", cd_sec); end
    rst = 1'b0;
    wait_cycles(8);
  endtask

  task automatic test_start();
    drive(1, 0, 0, 0);
    checks++; if (state  !== 3'd1) begin failures++; $display("FAIL start_state: got %0d want 1", state); end
    checks++; if (cd_sec !== 2'd1) begin failures++; $display("FAIL start_cd_sec: got %0d want 1", cd_sec); end
    checks++; if (run_en !== 1'b0) begin failures++; $display("FAIL start_run_en: got %0b want 0", run_en); end
    drive(0, 1, 1, 1); // all ignored during the countdown
    checks++; if (score !== 10'd0 || state !== 3'd1) begin failures++; $display("FAIL count_ignore: score %0d state %0d want 0/1", score, state); end
    wait_cycles(10);
    checks++; if (state !== 3'd1 || load !== 1'b0) begin failures++; $display("FAIL count_dwell: state %0d load %0b want 1/0", state, load); end
    step();
    checks++; if (state  !== 3'd2)   begin failures++; $display("FAIL run_state: got %0d want 2", state); end
    checks++; if (run_en !== 1'b1)   begin failures++; $display("FAIL run_run_en: got %0b want 1", run_en); end
    checks++; if (load   !== 1'b1)   begin failures++; $display("FAIL run_load: got %0b want 1", load); end
    checks++; if (cd_sec !== 2'd0)   begin failures++; $display("FAIL run_cd_sec: got %0d want 0", cd_sec); end
    step();
    checks++; if (load !== 1'b0 || run_en !== 1'b1) begin failures++; $display("FAIL load_width: load %0b run_en %0b want 0/1", load, run_en); end
  endtask

  task automatic test_level_up();
    drive(1, 0, 0, 0);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL start_ignored_run: got %0d want 2", state); end
    drive(0, 0, 1, 0);
    checks++; if (score !== 10'd1 || state !== 3'd2) begin failures++; $display("FAIL hit1: score %0d state %0d want 1/2", score, state); end
    drive(0, 0, 1, 0);
    checks++; if (score  !== 10'd2)  begin failures++; $display("FAIL hit2_score: got %0d want 2", score); end
    checks++; if (state  !== 3'd4)   begin failures++; $display("FAIL hit2_state: got %0d want 4", state); end
    checks++; if (level  !== 4'd2)   begin failures++; $display("FAIL hit2_level: got %0d want 2", level); end
    checks++; if (period !== 32'd70) begin failures++; $display("FAIL hit2_period: got %0d want 70", period); end
    checks++; if (run_en !== 1'b0)   begin failures++; $display("FAIL level_run_en: got %0b want 0", run_en); end
    wait_cycles(7);
    checks++; if (state !== 3'd4 || load !== 1'b0) begin failures++; $display("FAIL level_dwell: state %0d load %0b want 4/0", state, load); end
    step();
    checks++; if (state !== 3'd2 || load !== 1'b1 || period !== 32'd70) begin failures++; $display("FAIL level_exit: state %0d load %0b period %0d want 2/1/70", state, load, period); end
    drive(0, 0, 1, 0); drive(0, 0, 1, 0);
    checks++; if (level !== 4'd3 || period !== 32'd40) begin failures++; $display("FAIL level3: level %0d period %0d want 3/40", level, period); end
    wait_cycles(8);
    drive(0, 0, 1, 0); drive(0, 0, 1, 0);
    checks++; if (level !== 4'd4 || period !== 32'd20) begin failures++; $display("FAIL level4_clamp: level %0d period %0d want 4/20", level, period); end
    wait_cycles(8);
    checks++; if (state !== 3'd2 || load !== 1'b1 || score !== 10'd6) begin failures++; $display("FAIL level4_exit: state %0d load %0b score %0d want 2/1/6", state, load, score); end
  endtask

  task automatic test_pause();
    drive(0, 1, 0, 0);
    checks++; if (state !== 3'd3 || run_en !== 1'b0) begin failures++; $display("FAIL pause_enter: state %0d run_en %0b want 3/0", state, run_en); end
    drive(0, 0, 1, 0);
    checks++; if (score !== 10'd6 || state !== 3'd3) begin failures++; $display("FAIL pause_hit: score %0d state %0d want 6/3", score, state); end
    drive(0, 1, 0, 0);
    checks++; if (state !== 3'd2 || load !== 1'b0 || run_en !== 1'b1) begin failures++; $display("FAIL pause_exit: state %0d load %0b run_en %0b want 2/0/1", state, load, run_en); end
  endtask

  task automatic test_miss();
    drive(0, 0, 1, 1);
`ifdef GAME_SEQ_LIVES_EN
    checks++; if (lives !== 2'd2)  begin failures++; $display("FAIL miss1_lives: got %0d want 2", lives); end
    checks++; if (score !== 10'd6) begin failures++; $display("FAIL miss1_score: got %0d want 6", score); end
    checks++; if (state !== 3'd1 || cd_sec !== 2'd1) begin failures++; $display("FAIL miss1_state: state %0d cd %0d want 1/1", state, cd_sec); end
    checks++; if (level !== 4'd4 || period !== 32'd20) begin failures++; $display("FAIL miss1_keep: level %0d period %0d want 4/20", level, period); end
    wait_cycles(12);
    checks++; if (state !== 3'd2 || load !== 1'b1) begin failures++; $display("FAIL miss1_rerun: state %0d load %0b want 2/1", state, load); end
    drive(0, 0, 0, 1);
    checks++; if (lives !== 2'd1 || state !== 3'd1) begin failures++; $display("FAIL miss2: lives %0d state %0d want 1/1", lives, state); end
    wait_cycles(12);
    drive(0, 0, 0, 1);
`endif
    checks++; if (state  !== 3'd5) begin failures++; $display("FAIL over_state: got %0d want 5", state); end
    checks++; if (run_en !== 1'b0) begin failures++; $display("FAIL over_run_en: got %0b want 0", run_en); end
    checks++; if (lives  !== 2'd0) begin failures++; $display("FAIL over_lives: got %0d want 0", lives); end
    drive(0, 1, 1, 0);
    checks++; if (state !== 3'd5 || score !== 10'd6 || level !== 4'd4 || period !== 32'd20) begin failures++; $display("FAIL over_hold: state %0d score %0d level %0d period %0d want 5/6/4/20", state, score, level, period); end
    drive(1, 0, 0, 0);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL over_to_idle: got %0d want 0", state); end
  endtask

  task automatic test_reset_mid_run();
    drive(1, 0, 0, 0);
    checks++; if (score !== 10'd0 || level !== 4'd1 || period !== 32'd100 || lives !== RST_LIVES) begin failures++; $display("FAIL restart_init: score %0d level %0d period %0d lives %0d", score, level, period, lives); end
    wait_cycles(12);
    drive(0, 0, 1, 0); drive(0, 0, 1, 0);
    wait_cycles(8);
    drive(0, 0, 1, 0); drive(0, 0, 1, 0);
    wait_cycles(8);
    drive(0, 0, 1, 0);
    checks++; if (level !== 4'd3 || score !== 10'd5 || state !== 3'd2) begin failures++; $display("FAIL pre_reset: level %0d score %0d state %0d want 3/5/2", level, score, state); end
    rst = 1'b1;
    drive(0, 0, 1, 0);
    rst = 1'b0;
    checks++; if (state !== 3'd0 || run_en !== 1'b0 || load !== 1'b0) begin failures++; $display("FAIL midrst_ctrl: state %0d run_en %0b load %0b want 0/0/0", state, run_en, load); end
    checks++; if (period !== 32'd100 || level !== 4'd1 || score !== 10'd0) begin failures++; $display("FAIL midrst_data: period %0d level %0d score %0d want 100/1/0", period, level, score); end
    checks++; if (lives !== RST_LIVES || cd_sec !== 2'd0) begin failures++; $display("FAIL midrst_disp: lives %0d cd %0d want %0d/0", lives, cd_sec, RST_LIVES); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_level_up();
    test_pause();
    test_miss();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Round/level controller for the LED-chase reaction game. Sequences the LED-shift datapath and stopwatch: start countdown, run, pause, level-up with faster shift period, and game over. It issues run-enable, a reload pulse and the shift period to the datapath, and consumes hit/miss events from it. Its outputs also drive the HEX state, level and score displays.

## Interface
- `TICK_DIV`, 500000: CLK cycles per 10 ms tick.
- `COUNT_TICKS`, 300: ticks spent in COUNT (3 s).
- `LEVEL_TICKS`, 100: ticks spent in LEVEL (1 s).
- `BASE_PERIOD`, 5000000: shift period at level 1, in CLK cycles.
- `PERIOD_STEP`, 500000: period decrease per level.
- `MIN_PERIOD`, 1000000: lower bound on the period.
- `HITS_PER_LEVEL`, 4: hits needed to advance one level.
- `MAX_LEVEL`, 9: level saturation value.
- `LIVES`, 3: starting lives (only with `GAME_SEQ_LIVES_EN`).
- `CLK` in 1: clock; every register samples on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `start_p` in 1: one-cycle start request.
- `pause_p` in 1: one-cycle pause/resume toggle.
- `hit_p` in 1: one-cycle pulse; the player stopped on target.
- `miss_p` in 1: one-cycle pulse; the chase reached an edge LED.
- `run_en` out 1: datapath shifts while high.
- `load` out 1: one-cycle pulse; datapath reloads its start pattern and latches `period`.
- `period` out 32: current shift period.
- `level` out 4: current level, 1..`MAX_LEVEL`.
- `lives` out 2: remaining lives.
- `score` out 10: total hits, saturating at 999.
- `cd_sec` out 2: remaining countdown seconds (3, 2, 1), 0 outside COUNT.
- `state` out 3: encoded state for display.

## Operation
- States: IDLE=0, COUNT=1, RUN=2, PAUSE=3, LEVEL=4, OVER=5.
- IDLE: `start_p` -> COUNT. On this transition: `score`=0, `level`=1, `lives`=`LIVES`, `period`=`BASE_PERIOD`, tick counter cleared.
- COUNT: after `COUNT_TICKS` ticks -> RUN with `load`. `pause_p`, `hit_p` and `miss_p` are ignored.
- `cd_sec` = ceil(remaining_ticks/100), clamped to 1..3.
- RUN: `run_en`=1. Event priority is miss > hit > pause; at most one event acts per cycle.
  - `hit_p`: `score`+1, saturating at 999; hit counter +1. When the hit counter reaches `HITS_PER_LEVEL` and `level` < `MAX_LEVEL`, the hit counter clears and the block goes to LEVEL. At `MAX_LEVEL` the hit counter clears and the block stays in RUN.
  - `miss_p`: `lives`-1. If the result is 0 -> OVER. Otherwise -> COUNT, keeping the current level and period.
  - `pause_p` -> PAUSE.
- PAUSE: `run_en`=0. `pause_p` -> RUN with no `load`. hit and miss are ignored.
- LEVEL: `level`+1 on entry. `period` = max(`BASE_PERIOD` - (`level`-1)·`PERIOD_STEP`, `MIN_PERIOD`), computed with 33-bit signed arithmetic so no underflow wraps. After `LEVEL_TICKS` ticks -> RUN with `load`.
- OVER: `run_en`=0. `score`, `level` and `period` are held for display. `start_p` -> IDLE.
- `start_p` is ignored in every state except IDLE and OVER.

## Timing
- All outputs are registered. Values after reset: `state`=IDLE, `run_en`=0, `load`=0, `period`=`BASE_PERIOD`, `level`=1, `lives`=`LIVES`, `score`=0, `cd_sec`=0.
- An input pulse at cycle N changes `state` and the counters visible at cycle N+1.
- `run_en` rises in the same cycle `state` becomes RUN.
- `load` is high for exactly one cycle: the first cycle of RUN entered from COUNT or LEVEL, never from PAUSE.
- `period` is stable for at least one cycle before `load`.
- The tick prescaler runs only in COUNT and LEVEL, and clears on entry to either.
- A state's dwell ends on the cycle its final tick completes. COUNT occupies `COUNT_TICKS`·`TICK_DIV` cycles.
- `RESET` asserted in any state, including mid-countdown or in PAUSE, returns all outputs to their reset values on the next edge. It overrides every other input.
- Pulses wider than one cycle are treated as repeated events. The upstream pulse generators guarantee single-cycle pulses.

## Configuration
- `GAME_SEQ_LIVES_EN` defined: lives behave as in Operation.
- Undefined: the `lives` output is tied to 0, there is no lives register, and any `miss_p` in RUN goes directly to OVER.

## Structure
- Shared package `game_pkg` holds:
  - the state encoding localparams (IDLE..OVER) and `STATE_W`=3;
  - `SCORE_MAX`=999;
  - the display widths (`SCORE_W`=10, `LEVEL_W`=4).
- Sub-module `tick_prescaler`:
  - parameter `DIV`; inputs `CLK`, `RESET`, `clr`, `en`; output `tick`, a one-cycle pulse every `DIV` enabled cycles;
  - instantiated once, with `clr` asserted on COUNT/LEVEL entry.
- FSM, counters and period computation live in `game_sequencer`.

## Test plan
Scenarios use `TICK_DIV`=4, `COUNT_TICKS`=3, `LEVEL_TICKS`=2, `BASE_PERIOD`=100, `PERIOD_STEP`=30, `MIN_PERIOD`=20, `HITS_PER_LEVEL`=2, `LIVES`=3.
- Start: `start_p` at cycle 10 -> `state`=1 at cycle 11, `cd_sec`=1. `state`=2, `run_en`=1 and `load`=1 at cycle 23. `load`=0 at cycle 24.
- Level-up: two `hit_p` in RUN -> `score`=2, `state`=4, `level`=2, `period`=70. 8 cycles later `load` pulses with `period`=70. A third level-up gives `period`=20 (clamped, no wrap).
- Pause: `pause_p` in RUN -> `run_en`=0 and `state`=3. `hit_p` in PAUSE leaves `score` unchanged. A second `pause_p` returns `state`=2 with no `load`.
- Miss and simultaneous events: `miss_p` and `hit_p` in the same cycle -> `lives` 3->2, `score` unchanged, `state`=1. Three misses total -> `state`=5 and `run_en`=0.
- Reset mid-run: `RESET` high for one cycle at `level`=3, `score`=5 -> all outputs at reset values on the next edge, `period`=100.
- Macro off: build without `GAME_SEQ_LIVES_EN`; first `miss_p` -> `state`=5 and `lives`=0.
